memref_port_responder: RTL

//  Synthesizable responder for one HIR/HLS memref port. It answers kernel addr/rd_en/wr_en accesses

---
 rtl/memref_port_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/memref_port_responder.sv
// rtl/memref_port_responder.sv - SIZE x WIDTH memref port responder with kernel access and host LOAD/DUMP streams
// Kernel reads/writes are served only while idle; the host FSM owns the array during LOAD and DUMP.
module memref_port_responder #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 64,
  parameter int ADDR_W     = $clog2(SIZE),
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] k_addr,
  input  logic              k_rd_en,
  input  logic              k_wr_en,
  input  logic [WIDTH-1:0]  k_wr_data,
  output logic [WIDTH-1:0]  k_rd_data,
  output logic              k_rd_valid,
  output logic              k_err,
  input  logic              h_start,
  input  logic              h_mode,
  output logic              h_busy,
  output logic              h_done,
  input  logic              h_in_valid,
  output logic              h_in_ready,
  input  logic [WIDTH-1:0]  h_in_data,
  output logic              h_out_valid,
  input  logic              h_out_ready,
  output logic [WIDTH-1:0]  h_out_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_DUMP_RD   = 3'd2;
  localparam logic [2:0] S_DUMP_WAIT = 3'd3;
  localparam logic [2:0] S_DUMP_OUT  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        wait_cnt;
  logic [WIDTH-1:0]  mem [SIZE];
  logic              pipe_valid [RD_LATENCY];
  logic [WIDTH-1:0]  pipe_data  [RD_LATENCY];
  logic [WIDTH-1:0]  out_data;
  logic              err;

  logic              idle;
  logic              k_addr_ok;
  logic              k_rd_fire;
  logic              k_wr_fire;
  logic              k_access_err;
  logic              load_fire;
  logic              out_fire;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic [WIDTH-1:0]  k_rd_word;

  assign idle         = (state == S_IDLE);
  assign k_addr_ok    = ({1'b0, k_addr} < SIZE_C);
  assign k_rd_fire    = idle & k_rd_en;
  assign k_wr_fire    = idle & k_wr_en & k_addr_ok;
  assign k_access_err = (!idle & (k_rd_en | k_wr_en)) | (k_rd_en & k_wr_en);
  assign load_fire    = (state == S_LOAD) & h_in_valid;
  assign out_fire     = (state == S_DUMP_OUT) & h_out_ready;
  assign cnt_last     = (cnt == LAST_C);
  assign cnt_addr     = cnt[ADDR_W-1:0];
  // Read happens before the same-edge write lands, so rd+wr returns the old word.
  assign k_rd_word    = k_addr_ok ? mem[k_addr] : '0;

  // Kernel and host writers are mutually exclusive: the kernel only writes while idle.
  always_ff @(posedge clk) begin
    if (k_wr_fire) begin
      mem[k_addr] <= k_wr_data;
    end else if (load_fire) begin
      mem[cnt_addr] <= h_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      out_data <= '0;
      err      <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= '0;
      end
    end else begin
      // The read pipe keeps shifting while busy so reads issued before h_start complete.
      pipe_valid[0] <= k_rd_fire;
      pipe_data[0]  <= k_rd_fire ? k_rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end

      if (k_access_err) begin
        err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (h_start) begin
            cnt   <= '0;
            state <= h_mode ? S_DUMP_RD : S_LOAD;
          end
        end
        S_LOAD: begin
          if (h_in_valid) begin
            cnt <= cnt + CNT_ONE;
            if (cnt_last) begin
              state <= S_IDLE;
            end
          end
        end
        S_DUMP_RD: begin
          out_data <= mem[cnt_addr];
          wait_cnt <= '0;
          state    <= (RD_LATENCY > 1) ? S_DUMP_WAIT : S_DUMP_OUT;
        end
        S_DUMP_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_DUMP_OUT;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_DUMP_OUT: begin
          if (h_out_ready) begin
            cnt   <= cnt + CNT_ONE;
            state <= cnt_last ? S_IDLE : S_DUMP_RD;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign k_rd_valid  = pipe_valid[RD_LATENCY-1];
  assign k_rd_data   = pipe_data[RD_LATENCY-1];
  assign k_err       = err;
  assign h_busy      = !idle;
  assign h_in_ready  = (state == S_LOAD);
  assign h_out_valid = (state == S_DUMP_OUT);
  assign h_out_data  = out_data;
  assign h_done      = (load_fire | out_fire) & cnt_last;

endmodule
